// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Hunts for a two-byte sync header behind the UART receiver,
//                buffers a length-prefixed payload, verifies an 8-bit additive
//                checksum and releases good payloads as a burst of writes.
//                Rejected or stalled frames are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter logic [7:0] SYNC0   = 8'hA5,
    parameter logic [7:0] SYNC1   = 8'h5A,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iValid,
    input  logic [7:0] iData,
    output logic       oWrEn,
    output logic [3:0] oAddr,
    output logic [7:0] oData,
    output logic       oFrameDone,
    output logic       oFrameOk,
    output logic [4:0] oLen,
    output logic [7:0] oErrCnt,
    output logic       oBusy
);

    typedef enum logic [2:0] {
        S_HUNT0, S_HUNT1, S_LEN, S_PAYLOAD, S_CSUM, S_DUMP, S_DONE, S_ERR
    } state_t;

    localparam int              c_TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [7:0]      c_MAX_LEN8 = 8'(MAX_LEN);

    state_t          state_q, state_d;
    logic            vprev_q;
    logic [4:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [3:0]      idx_q, idx_d;
    logic [c_TW-1:0] tmo_q, tmo_d;
    logic            pend_v_q, pend_v_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic            ok_q, ok_d;
    logic [4:0]      olen_q, olen_d;
    logic [7:0]      errcnt_q, errcnt_d;
    logic [7:0]      pay_mem_q [MAX_LEN];

    logic            w_accept;
    logic            w_flush;
    logic            w_byte_v;
    logic [7:0]      w_byte;
    logic            w_last;
    logic            w_timed;
    logic            w_err;
    logic            w_mem_we;

    // A byte is taken on the rising edge of iValid only.
    assign w_accept = iValid & ~vprev_q;
    // While the payload is being released (or a result is reported) incoming
    // bytes are parked in the pending register instead of being parsed.
    assign w_flush  = (state_q == S_DUMP) || (state_q == S_DONE) || (state_q == S_ERR);
    // A parked byte takes priority over a fresh one once parsing resumes.
    assign w_byte_v = ~w_flush & (pend_v_q | w_accept);
    assign w_byte   = pend_v_q ? pend_data_q : iData;
    assign w_last   = ({1'b0, idx_q} == (len_q - 5'd1));
    assign w_timed  = (state_q == S_HUNT1) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);

    // Next-state, datapath and result bookkeeping for the frame parser.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        ok_d        = ok_q;
        olen_d      = olen_q;
        errcnt_d    = errcnt_q;
        w_err       = 1'b0;
        w_mem_we    = 1'b0;

        if (w_flush) begin
            if (w_accept) begin
                pend_v_d    = 1'b1;
                pend_data_d = iData;
            end
        end else if (pend_v_q) begin
            // The parked byte is consumed now; a simultaneous new edge is parked.
            pend_v_d    = w_accept;
            pend_data_d = w_accept ? iData : pend_data_q;
        end

        if (w_timed && !w_byte_v) begin
            if (tmo_q == c_TMO_LAST) begin
                w_err = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            S_HUNT0: begin
                if (w_byte_v && (w_byte == SYNC0)) begin
                    state_d = S_HUNT1;
                end
            end
            S_HUNT1: begin
                if (w_byte_v) begin
                    if (w_byte == SYNC1) begin
                        state_d = S_LEN;
                    end else if (w_byte != SYNC0) begin
                        state_d = S_HUNT0;
                    end
                end
            end
            S_LEN: begin
                if (w_byte_v) begin
                    if ((w_byte == 8'h00) || (w_byte > c_MAX_LEN8)) begin
                        w_err = 1'b1;
                    end else begin
                        len_d   = w_byte[4:0];
                        sum_d   = w_byte;
                        idx_d   = 4'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_byte_v) begin
                    w_mem_we = 1'b1;
                    sum_d    = sum_q + w_byte;
                    idx_d    = idx_q + 4'd1;
                    if (w_last) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_byte_v) begin
                    if (w_byte == sum_q) begin
                        idx_d   = 4'd0;
                        state_d = S_DUMP;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_DUMP: begin
                idx_d = idx_q + 4'd1;
                if (w_last) begin
                    idx_d   = 4'd0;
                    ok_d    = 1'b1;
                    olen_d  = len_q;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_HUNT0;
            end
        endcase

        if (w_err) begin
            state_d  = S_ERR;
            ok_d     = 1'b0;
            errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
        end
    end

    // State and control registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HUNT0;
            vprev_q     <= 1'b0;
            len_q       <= 5'd0;
            sum_q       <= 8'd0;
            idx_q       <= 4'd0;
            tmo_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= 8'd0;
            ok_q        <= 1'b0;
            olen_q      <= 5'd0;
            errcnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            vprev_q     <= iValid;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            ok_q        <= ok_d;
            olen_q      <= olen_d;
            errcnt_q    <= errcnt_d;
        end
    end

    // Payload buffer; contents are only meaningful after a full payload.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            pay_mem_q[idx_q] <= w_byte;
        end
    end

    assign oWrEn      = (state_q == S_DUMP);
    assign oAddr      = (state_q == S_DUMP) ? idx_q : 4'd0;
    assign oData      = (state_q == S_DUMP) ? pay_mem_q[idx_q] : 8'h00;
    assign oFrameDone = (state_q == S_DONE) || (state_q == S_ERR);
    assign oFrameOk   = ok_q;
    assign oLen       = olen_q;
    assign oErrCnt    = errcnt_q;
    assign oBusy      = (state_q != S_HUNT0);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser. Frames are built
//                from random payloads; expected writes and frame results come
//                from the frame construction and a small result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iValid = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oWrEn, oFrameDone, oFrameOk, oBusy;
    logic [3:0] oAddr;
    logic [7:0] oData, oErrCnt;
    logic [4:0] oLen;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  pl[$];
    logic [7:0]  pl1[$];
    logic [7:0]  tx[$];
    logic [11:0] wq[$];
    logic [13:0] fq[$];

    logic        exp_ok  = 1'b0;
    logic [4:0]  exp_len = 5'd0;
    logic [7:0]  exp_err = 8'd0;
    logic [13:0] got, e1;

    uart_frame_parser dut (
        .clk(clk), .rst(rst), .iValid(iValid), .iData(iData),
        .oWrEn(oWrEn), .oAddr(oAddr), .oData(oData),
        .oFrameDone(oFrameDone), .oFrameOk(oFrameOk), .oLen(oLen),
        .oErrCnt(oErrCnt), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    // Record writes and frame results away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (oWrEn)      wq.push_back({oAddr, oData});
            if (oFrameDone) fq.push_back({oFrameOk, oLen, oErrCnt});
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        iData  = b;
        iValid = 1'b1;
        repeat (hold) @(negedge clk);
        iValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drive_tx(input int hmin, input int hmax, input int first);
        for (int i = first; i < tx.size(); i++)
            send_byte(tx[i], $urandom_range(hmax, hmin), $urandom_range(2, 1));
    endtask

    // kind 0: good frame, 1: corrupted checksum, 2: illegal length byte.
    task automatic frame_from_pl(input int kind);
        logic [7:0] s;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(8'h5A);
        if (kind == 2) begin
            tx.push_back(($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 17)));
        end else begin
            s = 8'(pl.size());
            tx.push_back(s);
            foreach (pl[i]) begin
                tx.push_back(pl[i]);
                s = s + pl[i];
            end
            if (kind == 1) s = s ^ 8'($urandom_range(255, 1));
            tx.push_back(s);
        end
    endtask

    task automatic build_frame(input int len, input int kind);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        frame_from_pl(kind);
    endtask

    // Result model: what oFrameOk/oLen/oErrCnt must read after a frame attempt.
    task automatic model_frame(input bit good, input int len);
        exp_ok = good;
        if (good) exp_len = 5'(len);
        else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    task automatic wait_results(input int n, input int bound);
        for (int i = 0; i < bound && fq.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (oWrEn !== 1'b0) $display("FAIL reset_wren: got %b want 0", oWrEn); else n_pass++;
        n_checks++; if (oAddr !== 4'd0) $display("FAIL reset_addr: got %h want 0", oAddr); else n_pass++;
        n_checks++; if (oData !== 8'd0) $display("FAIL reset_data: got %h want 0", oData); else n_pass++;
        n_checks++; if (oFrameDone !== 1'b0) $display("FAIL reset_done: got %b want 0", oFrameDone); else n_pass++;
        n_checks++; if (oFrameOk !== 1'b0) $display("FAIL reset_ok: got %b want 0", oFrameOk); else n_pass++;
        n_checks++; if (oLen !== 5'd0) $display("FAIL reset_len: got %h want 0", oLen); else n_pass++;
        n_checks++; if (oErrCnt !== 8'd0) $display("FAIL reset_errcnt: got %h want 0", oErrCnt); else n_pass++;
        n_checks++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oBusy); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame;
        wq.delete(); fq.delete();
        pl = '{8'h11, 8'h22, 8'h33};
        frame_from_pl(0);
        drive_tx(3, 3, 0);
        model_frame(1, 3);
        wait_results(1, 80);
        n_checks++;
        if (fq.size() != 1) $display("FAIL good_done_count: got %0d want 1", fq.size());
        else begin
            n_pass++; got = fq.pop_front(); n_checks++;
            if (got !== {exp_ok, exp_len, exp_err}) $display("FAIL good_result: got %h want %h", got, {exp_ok, exp_len, exp_err});
            else n_pass++;
        end
        n_checks++;
        if (wq.size() != 3) $display("FAIL good_write_count: got %0d want 3", wq.size());
        else begin
            n_pass++;
            foreach (pl[i]) begin
                n_checks++;
                if (wq[i] !== {4'(i), pl[i]}) $display("FAIL good_write%0d: got %h want %h", i, wq[i], {4'(i), pl[i]});
                else n_pass++;
            end
        end
    endtask

    task automatic test_bad_checksum;
        wq.delete(); fq.delete();
        tx = '{8'hA5, 8'h5A, 8'h02, 8'h10, 8'h20, 8'h00};
        drive_tx(1, 3, 0);
        model_frame(0, 0);
        wait_results(1, 80);
        n_checks++;
        if (fq.size() != 1) $display("FAIL badcs_done_count: got %0d want 1", fq.size());
        else begin
            n_pass++; got = fq.pop_front(); n_checks++;
            if (got !== {exp_ok, exp_len, exp_err}) $display("FAIL badcs_result: got %h want %h", got, {exp_ok, exp_len, exp_err});
            else n_pass++;
        end
        n_checks++; if (wq.size() != 0) $display("FAIL badcs_writes: got %0d want 0", wq.size()); else n_pass++;
        // A good frame right after must still go through.
        wq.delete(); fq.delete();
        build_frame($urandom_range(16, 1), 0);
        drive_tx(1, 2, 0);
        model_frame(1, pl.size());
        wait_results(1, 80);
        n_checks++;
        if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
            $display("FAIL badcs_next_result: got %h want %h", (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
        else n_pass++;
        n_checks++;
        if (wq.size() != pl.size()) $display("FAIL badcs_next_writes: got %0d want %0d", wq.size(), pl.size());
        else begin
            n_pass++;
            foreach (pl[i]) begin
                n_checks++;
                if (wq[i] !== {4'(i), pl[i]}) $display("FAIL badcs_next_write%0d: got %h want %h", i, wq[i], {4'(i), pl[i]});
                else n_pass++;
            end
        end
    endtask

    task automatic test_len_violation;
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'($urandom_range(255, 17));
        for (int k = 0; k < 2; k++) begin
            wq.delete(); fq.delete();
            tx = '{8'hA5, 8'h5A, lens[k]};
            drive_tx(1, 3, 0);
            model_frame(0, 0);
            wait_results(1, 40);
            n_checks++;
            if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
                $display("FAIL len_violation%0d: got %h want %h", k, (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
            else n_pass++;
            n_checks++; if (oBusy !== 1'b0) $display("FAIL len_violation_busy%0d: got %b want 0", k, oBusy); else n_pass++;
            n_checks++; if (wq.size() != 0) $display("FAIL len_violation_writes%0d: got %0d want 0", k, wq.size()); else n_pass++;
        end
    endtask

    task automatic test_sync_hunt;
        wq.delete(); fq.delete();
        tx = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h7E, 8'h7F};
        drive_tx(1, 3, 0);
        model_frame(1, 1);
        wait_results(1, 40);
        n_checks++;
        if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
            $display("FAIL sync_hunt_result: got %h want %h", (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
        else n_pass++;
        n_checks++;
        if (wq.size() != 1 || wq[0] !== 12'h07E)
            $display("FAIL sync_hunt_write: got %h (count %0d) want 07e", (wq.size() > 0) ? wq[0] : 12'h0, wq.size());
        else n_pass++;
    endtask

    task automatic test_timeout;
        int elapsed = 0;
        wq.delete(); fq.delete();
        tx = '{8'hA5, 8'h5A, 8'h04, 8'h01};
        drive_tx(1, 3, 0);
        while (fq.size() == 0 && elapsed < 4400) begin
            @(negedge clk);
            elapsed++;
        end
        model_frame(0, 0);
        n_checks++;
        if (elapsed < 4000 || elapsed > 4110) $display("FAIL timeout_latency: got %0d cycles want about 4096", elapsed);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
            $display("FAIL timeout_result: got %h want %h", (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
        else n_pass++;
        n_checks++; if (oBusy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", oBusy); else n_pass++;
        n_checks++; if (wq.size() != 0) $display("FAIL timeout_writes: got %0d want 0", wq.size()); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n1;
        wq.delete(); fq.delete();
        build_frame(16, 0);
        pl1 = pl;
        drive_tx(1, 1, 0);
        // SYNC0 edge lands while the 16-byte payload is being released.
        send_byte(8'hA5, 1, 25);
        model_frame(1, 16);
        e1 = {exp_ok, exp_len, exp_err};
        build_frame($urandom_range(16, 1), 0);
        drive_tx(1, 2, 1);
        model_frame(1, pl.size());
        wait_results(2, 100);
        n_checks++;
        if (fq.size() != 2) $display("FAIL b2b_done_count: got %0d want 2", fq.size());
        else begin
            n_pass++; n_checks++;
            if (fq[0] !== e1) $display("FAIL b2b_first_result: got %h want %h", fq[0], e1); else n_pass++;
            n_checks++;
            if (fq[1] !== {exp_ok, exp_len, exp_err}) $display("FAIL b2b_second_result: got %h want %h", fq[1], {exp_ok, exp_len, exp_err});
            else n_pass++;
        end
        n1 = pl1.size();
        n_checks++;
        if (wq.size() != n1 + pl.size()) $display("FAIL b2b_write_count: got %0d want %0d", wq.size(), n1 + pl.size());
        else begin
            n_pass++;
            for (int i = 0; i < wq.size(); i++) begin
                n_checks++;
                if (i < n1 && wq[i] !== {4'(i), pl1[i]}) $display("FAIL b2b_write%0d: got %h want %h", i, wq[i], {4'(i), pl1[i]});
                else if (i >= n1 && wq[i] !== {4'(i - n1), pl[i - n1]}) $display("FAIL b2b_write%0d: got %h want %h", i, wq[i], {4'(i - n1), pl[i - n1]});
                else n_pass++;
            end
        end
    endtask

    task automatic test_random;
        int kind;
        for (int it = 0; it < 25; it++) begin
            wq.delete(); fq.delete();
            kind = $urandom_range(3, 0);
            build_frame($urandom_range(16, 1), (kind < 2) ? 0 : kind - 1);
            if ($urandom_range(1, 0) == 1) send_byte(8'($urandom), 1, 1);
            drive_tx(1, 3, 0);
            model_frame(kind < 2, pl.size());
            wait_results(1, 80);
            n_checks++;
            if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
                $display("FAIL rand%0d_result: got %h want %h", it, (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
            else n_pass++;
            n_checks++;
            if (oFrameOk !== exp_ok || oLen !== exp_len) $display("FAIL rand%0d_held: got %b/%0d want %b/%0d", it, oFrameOk, oLen, exp_ok, exp_len);
            else n_pass++;
            n_checks++;
            if (wq.size() != ((kind < 2) ? pl.size() : 0)) $display("FAIL rand%0d_write_count: got %0d", it, wq.size());
            else begin
                n_pass++;
                foreach (wq[i]) begin
                    n_checks++;
                    if (wq[i] !== {4'(i), pl[i]}) $display("FAIL rand%0d_write%0d: got %h want %h", it, i, wq[i], {4'(i), pl[i]});
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_err_saturation;
        fq.delete();
        for (int k = 0; k < 260; k++) begin
            tx = '{8'hA5, 8'h5A, 8'h00};
            drive_tx(1, 1, 0);
            model_frame(0, 0);
        end
        repeat (4) @(negedge clk);
        n_checks++; if (fq.size() != 260) $display("FAIL sat_done_count: got %0d want 260", fq.size()); else n_pass++;
        n_checks++; if (oErrCnt !== exp_err) $display("FAIL sat_errcnt: got %0d want %0d", oErrCnt, exp_err); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        build_frame(8, 0);
        for (int i = 0; i < 6; i++) send_byte(tx[i], 1, 1);
        rst = 1'b0;
        #1;
        exp_ok = 1'b0; exp_len = 5'd0; exp_err = 8'd0;
        n_checks++;
        if ({oWrEn, oAddr, oData, oFrameDone, oFrameOk, oLen, oErrCnt, oBusy} !== 29'd0)
            $display("FAIL midreset_outputs: got busy=%b err=%0d ok=%b len=%0d", oBusy, oErrCnt, oFrameOk, oLen);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wq.delete(); fq.delete();
        build_frame($urandom_range(16, 1), 0);
        drive_tx(1, 2, 0);
        model_frame(1, pl.size());
        wait_results(1, 80);
        n_checks++;
        if (fq.size() != 1 || fq[0] !== {exp_ok, exp_len, exp_err})
            $display("FAIL midreset_next_result: got %h want %h", (fq.size() > 0) ? fq[0] : 14'h0, {exp_ok, exp_len, exp_err});
        else n_pass++;
        n_checks++;
        if (wq.size() != pl.size()) $display("FAIL midreset_next_writes: got %0d want %0d", wq.size(), pl.size());
        else begin
            n_pass++;
            foreach (pl[i]) begin
                n_checks++;
                if (wq[i] !== {4'(i), pl[i]}) $display("FAIL midreset_write%0d: got %h want %h", i, wq[i], {4'(i), pl[i]});
                else n_pass++;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_violation();
        test_sync_hunt();
        test_timeout();
        test_back_to_back();
        test_random();
        test_err_saturation();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
